// File: rtl/mult_share_pkg.sv
// Shared types for the multiplier-sharing arbiter: FSM state, in-flight tag, ID width helper.
package mult_share_pkg;

    localparam int unsigned TAG_ID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_id,
    output logic [ID_W-1:0]  o_next_ptr,
    output logic             o_any
);

    always_comb begin : p_pick
        logic [ID_W-1:0] idx;
        o_gnt      = '0;
        o_gnt_id   = '0;
        o_next_ptr = i_ptr;
        o_any      = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(i_ptr) + k) % N_REQ);
            if (i_en && !o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_id   = idx;
                o_next_ptr = ID_W'((32'(idx) + 32'd1) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined multiplier among N_REQ clients.
// Optional MULT_SHARE_ARB_CHECK_EN: sticky err when mul_done disagrees with the head tag.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter  int unsigned WL      = 32,
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned MUL_LAT = 4,
    localparam int unsigned ID_W    = id_width(N_REQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*WL-1:0] req_a,
    input  logic [N_REQ*WL-1:0] req_b,
    input  logic                flush,
    output logic                flush_done,
    output logic                busy,
    output logic                mul_start,
    output logic [WL-1:0]       mul_multiplier,
    output logic [WL-1:0]       mul_multiplicand,
    input  logic                mul_done,
    input  logic [2*WL-1:0]     mul_product,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [2*WL-1:0]     rsp_product,
    output logic                err
);

    state_e          r_state, w_state_nxt;
    logic [ID_W-1:0] r_ptr, w_next_ptr, w_gnt_id;
    logic            w_any_gnt, w_en, w_tags_pre, w_empty, w_flush_done_nxt;
    logic            r_issue_vld, r_busy, r_flush_done, r_rsp_valid;
    logic [ID_W-1:0] r_issue_id, r_rsp_id;
    logic [WL-1:0]   r_mul_a, r_mul_b;
    logic [2*WL-1:0] r_rsp_product;
    tag_t            r_tag [MUL_LAT];

    // Reset is folded in so req_ready reads 0 while reset is held.
    assign w_en = reset_n && (r_state != ST_DRAIN) && !flush;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .i_req      (req_valid),
        .i_ptr      (r_ptr),
        .i_en       (w_en),
        .o_gnt      (req_ready),
        .o_gnt_id   (w_gnt_id),
        .o_next_ptr (w_next_ptr),
        .o_any      (w_any_gnt)
    );

    always_comb begin
        w_tags_pre = 1'b0;
        for (int unsigned i = 0; i + 1 < MUL_LAT; i++) begin
            w_tags_pre = w_tags_pre | r_tag[i].valid;
        end
    end

    assign w_empty = !r_issue_vld && !w_tags_pre && !r_tag[MUL_LAT-1].valid;

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush)          w_state_nxt = ST_DRAIN;
                else if (w_any_gnt) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (flush)                       w_state_nxt = ST_DRAIN;
                else if (w_empty && !w_any_gnt)  w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt      = ST_IDLE;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_issue_vld   <= 1'b0;
            r_issue_id    <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_busy        <= 1'b0;
            r_flush_done  <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
            r_issue_vld  <= w_any_gnt;
            // busy mirrors next cycle's occupancy of the issue reg and tag pipe
            r_busy       <= w_any_gnt | r_issue_vld | w_tags_pre;
            if (w_any_gnt) begin
                r_ptr      <= w_next_ptr;
                r_issue_id <= w_gnt_id;
                r_mul_a    <= req_a[32'(w_gnt_id)*WL +: WL];
                r_mul_b    <= req_b[32'(w_gnt_id)*WL +: WL];
            end
            r_rsp_valid <= mul_done & r_tag[MUL_LAT-1].valid;
            if (mul_done && r_tag[MUL_LAT-1].valid) begin
                r_rsp_id      <= r_tag[MUL_LAT-1].id[ID_W-1:0];
                r_rsp_product <= mul_product;
            end
        end
    end

    // Tag pipe aligned so the last entry is valid in the cycle mul_done is due.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= '{valid: r_issue_vld, id: TAG_ID_W'(r_issue_id)};
            for (int unsigned i = 1; i < MUL_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

`ifdef MULT_SHARE_ARB_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               r_err <= 1'b0;
        else if (mul_done != r_tag[MUL_LAT-1].valid) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign mul_start        = r_issue_vld;
    assign mul_multiplier   = r_mul_a;
    assign mul_multiplicand = r_mul_b;
    assign busy             = r_busy;
    assign flush_done       = r_flush_done;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_id           = r_rsp_id;
    assign rsp_product      = r_rsp_product;

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin scheduler sharing one pipelined multiplier (fixed-latency `start`/`done` unit) between `N_REQ` requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues at most one operation per cycle, tracks in-flight requester IDs in a tag pipeline aligned to the multiplier latency, and returns each product with its requester ID. Sits between compute clients and the single shared multiplier instance; also provides a flush/drain control for the owning controller.

## Interface
- `WL`, 32, operand width; product is `2*WL`
- `N_REQ`, 4, number of requesters (≥2)
- `MUL_LAT`, 4, multiplier `start`→`done` latency in cycles (≥1); must equal the attached multiplier's done pipeline depth
- `ID_W`, `$clog2(N_REQ)`, requester ID width (localparam)

- `clk` in 1 — single clock, all logic rising-edge
- `reset_n` in 1 — asynchronous, active-low reset
- `req_valid` in N_REQ — requester i has an operand pair
- `req_ready` out N_REQ — one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `req_a` in N_REQ*WL — multiplier operands, requester i at `[i*WL +: WL]`
- `req_b` in N_REQ*WL — multiplicand operands, same packing
- `flush` in 1 — level; stop granting and drain in-flight ops
- `flush_done` out 1 — one-cycle pulse when drain completes
- `busy` out 1 — ops in flight or issue register occupied
- `mul_start` out 1 — to multiplier `start`
- `mul_multiplier` out WL, `mul_multiplicand` out WL — to multiplier operands
- `mul_done` in 1, `mul_product` in 2*WL — from multiplier
- `rsp_valid` out 1 — product valid, one cycle
- `rsp_id` out ID_W — requester owning `rsp_product`
- `rsp_product` out 2*WL — result
- `err` out 1 — sticky protocol error (see Configuration)

## Operation
- FSM states: IDLE (no ops in flight), ACTIVE (issuing and/or ops in flight), DRAIN (flush seen, waiting for tag pipe empty).
- IDLE→ACTIVE on any grant; ACTIVE→IDLE when tag pipe empty, issue reg empty, no grant; IDLE/ACTIVE→DRAIN when `flush`=1; DRAIN→IDLE when tag pipe empty and issue reg empty, pulsing `flush_done` that cycle. DRAIN with nothing in flight exits next cycle.
- `req_ready` combinational: zero in DRAIN or when `flush`=1; else one-hot to first valid requester at or after the RR pointer. `flush` and `req_valid` in same cycle: no grant.
- RR pointer: after grant to i, pointer = i+1, wrapping N_REQ-1→0. Unchanged when no grant. Reset value 0.
- No response backpressure; responses are never dropped while tags are valid.
- Tag pipe: MUL_LAT entries of {valid, id}, shifted every cycle; entry 0 loaded with the issued op.
- Products passed unmodified; no arithmetic in this block.

## Timing
- Grant cycle T: operands registered; `mul_start`=1 and operands valid at T+1.
- `mul_done` expected at T+1+MUL_LAT; `rsp_valid`/`rsp_id`/`rsp_product` registered, valid at T+2+MUL_LAT.
- Throughput: one grant per cycle, back-to-back grants to different or same requester allowed.
- Reset values: `req_ready`=0 (combinational from IDLE/no valid), `mul_start`=0, operands 0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `flush_done`=0, `busy`=0, `err`=0, all tags invalid.
- Reset mid-operation: all in-flight tags discarded; the multiplier must be reset concurrently. `mul_done` arriving with head tag invalid produces no response.

## Configuration
- `MULT_SHARE_ARB_CHECK_EN` defined: `err` sets and holds (until reset) when `mul_done` ≠ head tag valid in the same cycle.
- Undefined: check logic omitted, `err` tied 0; mismatched `mul_done` silently ignored.

## Structure
- Package `mult_share_pkg`: FSM state enum, tag struct {valid, id}, ID width function.
- Sub-module `rr_arbiter` (N_REQ, req vector + pointer in, one-hot grant + next pointer out), combinational.

## Test plan
- Reset, single req0 a=3 b=5 at T -> `mul_start` at T+1, `rsp_valid` at T+2+MUL_LAT with id=0, product=15.
- All four `req_valid` held high 8 cycles -> grants 0,1,2,3,0,1,2,3 one per cycle; responses in same ID order.
- Pointer wrap: only req3 then req0 and req3 valid -> grant 3, then 0, then 3.
- `flush` with 3 ops in flight and req1 valid -> no grant; 3 responses; `flush_done` pulses once; return to IDLE.
- `reset_n` low mid-burst -> all outputs to reset values asynchronously; no responses after release.
- With `MULT_SHARE_ARB_CHECK_EN`: inject spurious `mul_done` with empty tag pipe -> `err`=1 and stays 1; without macro `err`=0.
